// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: register width, forward-enable bit positions,
// hazard FSM encoding and the bubble value of the EX shadow slot.
package pipeline_pkg;

  localparam int REG_ADDR_WIDTH = 5;

  localparam int FWD_OP1 = 0;
  localparam int FWD_OP2 = 1;

  typedef enum logic {
    RUN        = 1'b0,
    LOAD_STALL = 1'b1
  } hazard_state_t;

  typedef struct packed {
    logic [REG_ADDR_WIDTH-1:0] rd;
    logic                      we;
    logic                      load;
  } ex_slot_t;

  localparam ex_slot_t EX_BUBBLE = '0;

endpackage

// File: rtl/hazard_forward_detector_if.sv
// ID-stage view of the hazard/forward detector: decoded register fields and
// pipeline control in, stall and forward enables out.
interface hazard_forward_detector_if #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int CNT_WIDTH      = 32
);
  logic [REG_ADDR_WIDTH-1:0] ID_RS1;
  logic [REG_ADDR_WIDTH-1:0] ID_RS2;
  logic                      ID_USES_RS1;
  logic                      ID_USES_RS2;
  logic [REG_ADDR_WIDTH-1:0] ID_RD;
  logic                      ID_REG_WRITE_EN;
  logic                      ID_MEM_READ;
  logic                      FLUSH;
  logic                      MEM_BUSY;
  logic                      HAZARD_STALL;
  logic                      BUBBLE;
  logic [1:0]                MEM_FORWARD_EN;
  logic [1:0]                WB_FORWARD_EN;
  logic [CNT_WIDTH-1:0]      STALL_COUNT;

  modport master (
    output ID_RS1, ID_RS2, ID_USES_RS1, ID_USES_RS2, ID_RD,
           ID_REG_WRITE_EN, ID_MEM_READ, FLUSH, MEM_BUSY,
    input  HAZARD_STALL, BUBBLE, MEM_FORWARD_EN, WB_FORWARD_EN, STALL_COUNT
  );

  modport slave (
    input  ID_RS1, ID_RS2, ID_USES_RS1, ID_USES_RS2, ID_RD,
           ID_REG_WRITE_EN, ID_MEM_READ, FLUSH, MEM_BUSY,
    output HAZARD_STALL, BUBBLE, MEM_FORWARD_EN, WB_FORWARD_EN, STALL_COUNT
  );
endinterface

// File: rtl/hazard_forward_detector_reg_match.sv
// Source/destination comparator; register x0 never produces a match.
module reg_match #(
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic [REG_ADDR_WIDTH-1:0] rs,
  input  logic [REG_ADDR_WIDTH-1:0] rd,
  input  logic                      we,
  output logic                      match
);
  assign match = (rs != '0) && we && (rd == rs);
endmodule

// File: rtl/hazard_forward_detector.sv
// Shadow EX/MEM destination tracking, registered forward enables and
// load-use stall generation for the 5-stage pipeline.
module hazard_forward_detector
  import pipeline_pkg::*;
#(
  parameter int REG_ADDR_WIDTH = pipeline_pkg::REG_ADDR_WIDTH,
  parameter int CNT_WIDTH      = 32
) (
  input logic                      CLK,
  input logic                      RESET,
  hazard_forward_detector_if.slave bus
);

  logic [REG_ADDR_WIDTH-1:0] ex_rd;
  logic                      ex_we;
  logic                      ex_load;
  logic [REG_ADDR_WIDTH-1:0] mem_rd;
  logic                      mem_we;
  logic [1:0]                mem_fwd;
  logic [1:0]                wb_fwd;
  logic [CNT_WIDTH-1:0]      stall_count;
  hazard_state_t             state;

  logic ex_match_rs1, ex_match_rs2, mem_match_rs1, mem_match_rs2;
  logic load_use, hazard_stall;

  reg_match #(.REG_ADDR_WIDTH(REG_ADDR_WIDTH)) u_ex_rs1 (
    .rs(bus.ID_RS1), .rd(ex_rd), .we(ex_we), .match(ex_match_rs1)
  );
  reg_match #(.REG_ADDR_WIDTH(REG_ADDR_WIDTH)) u_ex_rs2 (
    .rs(bus.ID_RS2), .rd(ex_rd), .we(ex_we), .match(ex_match_rs2)
  );
  reg_match #(.REG_ADDR_WIDTH(REG_ADDR_WIDTH)) u_mem_rs1 (
    .rs(bus.ID_RS1), .rd(mem_rd), .we(mem_we), .match(mem_match_rs1)
  );
  reg_match #(.REG_ADDR_WIDTH(REG_ADDR_WIDTH)) u_mem_rs2 (
    .rs(bus.ID_RS2), .rd(mem_rd), .we(mem_we), .match(mem_match_rs2)
  );

  assign load_use = ex_load && ((bus.ID_USES_RS1 && ex_match_rs1) ||
                                (bus.ID_USES_RS2 && ex_match_rs2));
  assign hazard_stall = load_use && (state == RUN) && !bus.FLUSH && !bus.MEM_BUSY;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      ex_rd       <= '0;
      ex_we       <= 1'b0;
      ex_load     <= 1'b0;
      mem_rd      <= '0;
      mem_we      <= 1'b0;
      mem_fwd     <= '0;
      wb_fwd      <= '0;
      stall_count <= '0;
      state       <= RUN;
    end else if (!bus.MEM_BUSY) begin
      mem_rd <= ex_rd;
      mem_we <= ex_we;
      // Flush and load-use stall both inject a bubble; only the stall counts.
      if (bus.FLUSH || hazard_stall) begin
        ex_rd   <= '0;
        ex_we   <= EX_BUBBLE.we;
        ex_load <= EX_BUBBLE.load;
        mem_fwd <= '0;
        wb_fwd  <= '0;
        if (hazard_stall && (stall_count != '1))
          stall_count <= stall_count + CNT_WIDTH'(1);
        state <= hazard_stall ? LOAD_STALL : RUN;
      end else begin
        ex_rd            <= bus.ID_RD;
        ex_we            <= bus.ID_REG_WRITE_EN;
        ex_load          <= bus.ID_MEM_READ;
        mem_fwd[FWD_OP1] <= bus.ID_USES_RS1 && ex_match_rs1;
        mem_fwd[FWD_OP2] <= bus.ID_USES_RS2 && ex_match_rs2;
        wb_fwd[FWD_OP1]  <= bus.ID_USES_RS1 && mem_match_rs1 && !ex_match_rs1;
        wb_fwd[FWD_OP2]  <= bus.ID_USES_RS2 && mem_match_rs2 && !ex_match_rs2;
        state            <= RUN;
      end
    end
  end

  assign bus.HAZARD_STALL   = hazard_stall;
  assign bus.BUBBLE         = hazard_stall;
  assign bus.MEM_FORWARD_EN = mem_fwd;
  assign bus.WB_FORWARD_EN  = wb_fwd;
  assign bus.STALL_COUNT    = stall_count;

endmodule

// File: tb/tb_hazard_forward_detector.sv
// Scoreboard bench: hand-derived post-edge expectations are queued as each
// ID instruction is driven and compared one edge later.
module tb_hazard_forward_detector;

  typedef struct packed {
    logic [1:0]  mem;
    logic [1:0]  wb;
    logic [31:0] cnt;
  } exp_t;

  logic clk;
  logic rst;
  int unsigned checks;
  int unsigned errors;
  int unsigned step_no;
  exp_t sb[$];

  hazard_forward_detector_if #(.REG_ADDR_WIDTH(5), .CNT_WIDTH(32)) bus ();

  hazard_forward_detector #(.REG_ADDR_WIDTH(5), .CNT_WIDTH(32)) dut (
    .CLK  (clk),
    .RESET(rst),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s step %0d got %0h expected %0h", tag, step_no, got, exp);
    end
  endtask

  // Drives one ID instruction, checks the combinational stall before the
  // edge, and compares the registered outputs after it.
  task automatic step(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2, input logic u2,
                      input logic [4:0] rd, input logic we, input logic ld,
                      input logic fl, input logic bz,
                      input logic exp_hs, input logic [1:0] exp_mem, input logic [1:0] exp_wb,
                      input logic [31:0] exp_cnt);
    exp_t e;
    exp_t o;
    @(negedge clk);
    step_no++;
    bus.ID_RS1 = rs1; bus.ID_USES_RS1 = u1;
    bus.ID_RS2 = rs2; bus.ID_USES_RS2 = u2;
    bus.ID_RD = rd; bus.ID_REG_WRITE_EN = we; bus.ID_MEM_READ = ld;
    bus.FLUSH = fl; bus.MEM_BUSY = bz;
    #1;
    check_eq("hazard_stall", 64'(bus.HAZARD_STALL), 64'(exp_hs));
    check_eq("bubble", 64'(bus.BUBBLE), 64'(exp_hs));
    e.mem = exp_mem; e.wb = exp_wb; e.cnt = exp_cnt;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check_eq("scoreboard_empty", 64'(1), 64'(0));
    end else begin
      o = sb.pop_front();
      check_eq("mem_forward_en", 64'(bus.MEM_FORWARD_EN), 64'(o.mem));
      check_eq("wb_forward_en", 64'(bus.WB_FORWARD_EN), 64'(o.wb));
      check_eq("stall_count", 64'(bus.STALL_COUNT), 64'(o.cnt));
    end
  endtask

  initial begin
    checks = 0; errors = 0; step_no = 0;
    rst = 1'b1;
    bus.ID_RS1 = '0; bus.ID_USES_RS1 = 1'b0;
    bus.ID_RS2 = '0; bus.ID_USES_RS2 = 1'b0;
    bus.ID_RD = '0; bus.ID_REG_WRITE_EN = 1'b0; bus.ID_MEM_READ = 1'b0;
    bus.FLUSH = 1'b0; bus.MEM_BUSY = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_mem_fwd", 64'(bus.MEM_FORWARD_EN), 64'(0));
    check_eq("rst_wb_fwd", 64'(bus.WB_FORWARD_EN), 64'(0));
    check_eq("rst_count", 64'(bus.STALL_COUNT), 64'(0));
    check_eq("rst_stall", 64'(bus.HAZARD_STALL), 64'(0));
    @(negedge clk);
    rst = 1'b0;

    //   rs1 u1 rs2 u2 rd we ld  fl bz  hs mem    wb     cnt
    // EX->EX forwarding on both operands
    step(1, 1, 0, 0, 5, 1, 0, 0, 0, 0, 2'b00, 2'b00, 0);  // addi x5
    step(5, 1, 5, 1, 6, 1, 0, 0, 0, 0, 2'b11, 2'b00, 0);  // add x6,x5,x5
    // MEM->WB forwarding on operand 2
    step(0, 1, 0, 0, 7, 1, 0, 0, 0, 0, 2'b00, 2'b00, 0);  // addi x7,x0
    step(1, 1, 2, 1, 11, 1, 0, 0, 0, 0, 2'b00, 2'b00, 0); // unrelated
    step(1, 1, 7, 1, 8, 1, 0, 0, 0, 0, 2'b00, 2'b10, 0);  // sub x8,x1,x7
    // load-use: one stall, then WB forwarding
    step(2, 1, 0, 0, 9, 1, 1, 0, 0, 0, 2'b00, 2'b00, 0);  // lw x9
    step(9, 1, 2, 1, 10, 1, 0, 0, 0, 1, 2'b00, 2'b00, 1); // add x10,x9,x2 stalls
    step(9, 1, 2, 1, 10, 1, 0, 0, 0, 0, 2'b00, 2'b01, 1); // re-evaluated
    // x0 never forwards
    step(1, 1, 0, 0, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00, 1);  // addi x0
    step(0, 1, 0, 1, 1, 1, 0, 0, 0, 0, 2'b00, 2'b00, 1);  // add x1,x0,x0
    // load-use hidden by flush; load then sits in MEM slot
    step(2, 1, 0, 0, 3, 1, 1, 0, 0, 0, 2'b00, 2'b00, 1);  // lw x3
    step(3, 1, 1, 1, 12, 1, 0, 1, 0, 0, 2'b00, 2'b00, 1); // consumer, FLUSH
    step(3, 1, 0, 0, 13, 1, 0, 0, 0, 0, 2'b00, 2'b01, 1); // reads x3 from MEM slot
    // load-use held by MEM_BUSY for 3 cycles
    step(13, 1, 0, 0, 3, 1, 1, 0, 0, 0, 2'b01, 2'b00, 1); // lw x3,0(x13)
    step(3, 1, 3, 1, 14, 1, 0, 0, 1, 0, 2'b01, 2'b00, 1);
    step(3, 1, 3, 1, 14, 1, 0, 0, 1, 0, 2'b01, 2'b00, 1);
    step(3, 1, 3, 1, 14, 1, 0, 0, 1, 0, 2'b01, 2'b00, 1);
    step(3, 1, 3, 1, 14, 1, 0, 0, 0, 1, 2'b00, 2'b00, 2); // stall fires
    step(3, 1, 3, 1, 14, 1, 0, 0, 0, 0, 2'b00, 2'b11, 2);
    // both producers write x4: newest (EX) wins
    step(0, 0, 0, 0, 4, 1, 0, 0, 0, 0, 2'b00, 2'b00, 2);
    step(0, 0, 0, 0, 4, 1, 0, 0, 0, 0, 2'b00, 2'b00, 2);
    step(4, 1, 0, 0, 15, 1, 0, 0, 0, 0, 2'b01, 2'b00, 2);
    // asynchronous reset in the middle of a pending load-use stall
    step(0, 0, 0, 0, 9, 1, 1, 0, 0, 0, 2'b00, 2'b00, 2);  // lw x9
    @(negedge clk);
    step_no++;
    bus.ID_RS1 = 5'd9; bus.ID_USES_RS1 = 1'b1;
    bus.ID_RS2 = 5'd0; bus.ID_USES_RS2 = 1'b0;
    bus.ID_RD = 5'd16; bus.ID_REG_WRITE_EN = 1'b1; bus.ID_MEM_READ = 1'b0;
    #1;
    check_eq("pre_rst_stall", 64'(bus.HAZARD_STALL), 64'(1));
    check_eq("pre_rst_count", 64'(bus.STALL_COUNT), 64'(2));
    #1;
    rst = 1'b1;
    #1;
    check_eq("async_rst_stall", 64'(bus.HAZARD_STALL), 64'(0));
    check_eq("async_rst_bubble", 64'(bus.BUBBLE), 64'(0));
    check_eq("async_rst_mem_fwd", 64'(bus.MEM_FORWARD_EN), 64'(0));
    check_eq("async_rst_wb_fwd", 64'(bus.WB_FORWARD_EN), 64'(0));
    check_eq("async_rst_count", 64'(bus.STALL_COUNT), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    check_eq("scoreboard_drained", 64'(sb.size()), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
